// File: rtl/alu_op_sequencer.sv
// Drives operand/select registers onto a combinational ALU, waits a fixed settle
// time, and returns the captured result; sweep mode folds every combination into a signature.
module alu_op_sequencer #(
  parameter int INPUT_WIDTH   = 4,
  parameter int OUTPUT_WIDTH  = 8,
  parameter int SELECT_WIDTH  = 2,
  parameter int SETTLE_CYCLES = 1,
  parameter int SIG_WIDTH     = 16
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  cmd_valid,
  output logic                                  cmd_ready,
  input  logic [INPUT_WIDTH-1:0]                cmd_a,
  input  logic [INPUT_WIDTH-1:0]                cmd_b,
  input  logic [SELECT_WIDTH-1:0]               cmd_s,
  input  logic                                  cmd_sweep,
  output logic [INPUT_WIDTH-1:0]                alu_a,
  output logic [INPUT_WIDTH-1:0]                alu_b,
  output logic [SELECT_WIDTH-1:0]               alu_s,
  input  logic [OUTPUT_WIDTH-1:0]               alu_y,
  output logic                                  rsp_valid,
  input  logic                                  rsp_ready,
  output logic [OUTPUT_WIDTH-1:0]               rsp_y,
  output logic [SELECT_WIDTH-1:0]               rsp_s,
  output logic                                  busy,
  output logic                                  sweep_done,
  output logic [SIG_WIDTH-1:0]                  sweep_sig,
  output logic [2*INPUT_WIDTH+SELECT_WIDTH:0]   sweep_count
);

  localparam int IDX_W = 2*INPUT_WIDTH + SELECT_WIDTH;
  localparam int CNT_W = IDX_W + 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_RESP,
    ST_SW_DRIVE,
    ST_SW_SETTLE
  } state_t;

  state_t                    r_state;
  logic [IDX_W-1:0]          r_idx;
  logic [3:0]                r_settle;
  logic [INPUT_WIDTH-1:0]    r_alu_a;
  logic [INPUT_WIDTH-1:0]    r_alu_b;
  logic [SELECT_WIDTH-1:0]   r_alu_s;
  logic [OUTPUT_WIDTH-1:0]   r_rsp_y;
  logic [SELECT_WIDTH-1:0]   r_rsp_s;
  logic                      r_rsp_valid;
  logic                      r_sweep_done;
  logic [SIG_WIDTH-1:0]      r_sweep_sig;
  logic [CNT_W-1:0]          r_sweep_count;

  logic w_settle_last;
  logic w_idx_last;

  // Signature step: rotate left by one, then XOR in the zero-extended result.
  function automatic logic [SIG_WIDTH-1:0] sig_fold(input logic [SIG_WIDTH-1:0] sig,
                                                    input logic [OUTPUT_WIDTH-1:0] y);
    return {sig[SIG_WIDTH-2:0], sig[SIG_WIDTH-1]} ^ SIG_WIDTH'(y);
  endfunction

  assign w_settle_last = (r_settle == 4'(SETTLE_CYCLES - 1));
  assign w_idx_last    = &r_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_idx         <= '0;
      r_settle      <= '0;
      r_alu_a       <= '0;
      r_alu_b       <= '0;
      r_alu_s       <= '0;
      r_rsp_y       <= '0;
      r_rsp_s       <= '0;
      r_rsp_valid   <= 1'b0;
      r_sweep_done  <= 1'b0;
      r_sweep_sig   <= '0;
      r_sweep_count <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            if (cmd_sweep) begin
              r_sweep_sig   <= '0;
              r_sweep_count <= '0;
              r_sweep_done  <= 1'b0;
              r_idx         <= '0;
              r_state       <= ST_SW_DRIVE;
            end else begin
              r_alu_a <= cmd_a;
              r_alu_b <= cmd_b;
              r_alu_s <= cmd_s;
              r_state <= ST_DRIVE;
            end
          end
        end
        ST_DRIVE: begin
          r_settle <= '0;
          r_state  <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (w_settle_last) begin
            r_rsp_y     <= alu_y;
            r_rsp_s     <= r_alu_s;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RESP;
          end else begin
            r_settle <= r_settle + 4'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        // Index layout, MSB to LSB: select, operand A, operand B.
        ST_SW_DRIVE: begin
          r_alu_s  <= r_idx[IDX_W-1 -: SELECT_WIDTH];
          r_alu_a  <= r_idx[2*INPUT_WIDTH-1 -: INPUT_WIDTH];
          r_alu_b  <= r_idx[INPUT_WIDTH-1:0];
          r_settle <= '0;
          r_state  <= ST_SW_SETTLE;
        end
        ST_SW_SETTLE: begin
          if (w_settle_last) begin
            r_sweep_sig   <= sig_fold(r_sweep_sig, alu_y);
            r_sweep_count <= r_sweep_count + CNT_W'(1);
            if (w_idx_last) begin
              r_sweep_done <= 1'b1;
              r_state      <= ST_IDLE;
            end else begin
              r_idx   <= r_idx + IDX_W'(1);
              r_state <= ST_SW_DRIVE;
            end
          end else begin
            r_settle <= r_settle + 4'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready   = (r_state == ST_IDLE);
  assign busy        = (r_state != ST_IDLE);
  assign alu_a       = r_alu_a;
  assign alu_b       = r_alu_b;
  assign alu_s       = r_alu_s;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_y       = r_rsp_y;
  assign rsp_s       = r_rsp_s;
  assign sweep_done  = r_sweep_done;
  assign sweep_sig   = r_sweep_sig;
  assign sweep_count = r_sweep_count;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural ALU (add, multiply, shift, concat).
module tb_alu_op_sequencer;
  parameter int SETTLE = 1;

  localparam int IW = 4;
  localparam int OW = 8;
  localparam int SW = 2;
  localparam int GW = 16;
  localparam int CW = 2*IW + SW + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [IW-1:0] cmd_a, cmd_b;
  logic [SW-1:0] cmd_s;
  logic          cmd_sweep;
  logic [IW-1:0] alu_a, alu_b;
  logic [SW-1:0] alu_s;
  logic [OW-1:0] alu_y;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [OW-1:0] rsp_y;
  logic [SW-1:0] rsp_s;
  logic          busy;
  logic          sweep_done;
  logic [GW-1:0] sweep_sig;
  logic [CW-1:0] sweep_count;

  int n_checks = 0;
  int n_errors = 0;

  alu_op_sequencer #(
    .INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW), .SELECT_WIDTH(SW),
    .SETTLE_CYCLES(SETTLE), .SIG_WIDTH(GW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_s(cmd_s), .cmd_sweep(cmd_sweep),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_y(alu_y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y), .rsp_s(rsp_s),
    .busy(busy), .sweep_done(sweep_done), .sweep_sig(sweep_sig), .sweep_count(sweep_count)
  );

  always #5 clk = ~clk;

  function automatic logic [OW-1:0] alu_model(input logic [SW-1:0] s,
                                              input logic [IW-1:0] a,
                                              input logic [IW-1:0] b);
    logic [OW-1:0] ea, eb;
    ea = {4'b0, a};
    eb = {4'b0, b};
    case (s)
      2'd0:    return ea + eb;
      2'd1:    return ea * eb;
      2'd2:    return ea << b[2:0];
      default: return {a, b};
    endcase
  endfunction

  always_comb alu_y = alu_model(alu_s, alu_a, alu_b);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [IW-1:0] a, input logic [IW-1:0] b,
                          input logic [SW-1:0] s, input logic sweep);
    cmd_a = a; cmd_b = b; cmd_s = s; cmd_sweep = sweep;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    cmd_sweep = 1'b0;
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (!rsp_valid && n < 200) begin
      step();
      n++;
    end
  endtask

  task automatic wait_sweep(output int n);
    n = 0;
    while (!sweep_done && n < 20000) begin
      step();
      n++;
    end
  endtask

  logic [GW-1:0] exp_sig;
  logic [9:0]    idx;
  int            lat;

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_sweep = 1'b0;
    cmd_a = '0; cmd_b = '0; cmd_s = '0; rsp_ready = 1'b0;

    exp_sig = '0;
    for (int i = 0; i < 1024; i++) begin
      idx = 10'(i);
      exp_sig = {exp_sig[GW-2:0], exp_sig[GW-1]} ^
                GW'(alu_model(idx[9:8], idx[7:4], idx[3:0]));
    end

    #2;
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_sweep_sig", sweep_sig, 0);
    repeat (3) step();
    rst_n = 1'b1;
    step();
    chk("idle_cmd_ready", cmd_ready, 1);
    chk("idle_busy", busy, 0);
    chk("idle_alu_b", alu_b, 0);
    chk("idle_rsp_y", rsp_y, 0);
    chk("idle_sweep_done", sweep_done, 0);
    chk("idle_sweep_count", sweep_count, 0);

    // Single add with consumer ready
    rsp_ready = 1'b1;
    send_cmd(4'd3, 4'd5, 2'd0, 1'b0);
    chk("add_alu_a", alu_a, 3);
    chk("add_alu_b", alu_b, 5);
    chk("add_busy", busy, 1);
    chk("add_cmd_ready_busy", cmd_ready, 0);
    wait_rsp(lat);
    chk("add_latency", lat, 1 + SETTLE);
    chk("add_rsp_y", rsp_y, 8'h08);
    chk("add_rsp_s", rsp_s, 0);
    step();
    chk("add_rsp_done", rsp_valid, 0);
    chk("add_cmd_ready_back", cmd_ready, 1);

    // Multiply with consumer stalled
    rsp_ready = 1'b0;
    send_cmd(4'd7, 4'd9, 2'd1, 1'b0);
    wait_rsp(lat);
    chk("mul_latency", lat, 1 + SETTLE);
    for (int k = 0; k < 5; k++) begin
      cmd_valid = (k == 2);
      cmd_a = 4'd1; cmd_b = 4'd1; cmd_s = 2'd0;
      chk("stall_rsp_valid", rsp_valid, 1);
      chk("stall_rsp_y", rsp_y, 8'h3F);
      chk("stall_rsp_s", rsp_s, 1);
      step();
    end
    cmd_valid = 1'b0;
    chk("stall_end_valid", rsp_valid, 1);
    rsp_ready = 1'b1;
    step();
    chk("stall_release", rsp_valid, 0);
    chk("stall_alu_a_hold", alu_a, 7);
    step();
    chk("stall_no_queue", busy, 0);

    // Full sweep
    send_cmd(4'd0, 4'd0, 2'd0, 1'b1);
    chk("sweep_busy", busy, 1);
    wait_sweep(lat);
    chk("sweep_latency", lat, (1 + SETTLE) * 1024);
    chk("sweep_count", sweep_count, 1024);
    chk("sweep_sig", sweep_sig, exp_sig);
    chk("sweep_last_s", alu_s, 3);
    chk("sweep_last_a", alu_a, 15);
    chk("sweep_last_b", alu_b, 15);
    chk("sweep_no_rsp", rsp_valid, 0);
    step();
    chk("sweep_idle", busy, 0);

    // Single shift keeps sweep results
    send_cmd(4'd2, 4'd3, 2'd2, 1'b0);
    wait_rsp(lat);
    chk("shift_rsp_y", rsp_y, 8'h10);
    chk("shift_rsp_s", rsp_s, 2);
    step();
    chk("hold_sweep_done", sweep_done, 1);
    chk("hold_sweep_sig", sweep_sig, exp_sig);
    chk("hold_sweep_count", sweep_count, 1024);

    // Reset in the middle of a sweep
    send_cmd(4'd0, 4'd0, 2'd0, 1'b1);
    chk("sweep2_cleared_done", sweep_done, 0);
    repeat (600) step();
    chk("mid_sweep_count", sweep_count, 600 / (1 + SETTLE));
    chk("mid_sweep_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_alu_a", alu_a, 0);
    chk("arst_alu_s", alu_s, 0);
    chk("arst_rsp_y", rsp_y, 0);
    chk("arst_sweep_sig", sweep_sig, 0);
    chk("arst_sweep_count", sweep_count, 0);
    repeat (2) step();
    rst_n = 1'b1;
    step();
    chk("post_rst_ready", cmd_ready, 1);
    send_cmd(4'd2, 4'd2, 2'd3, 1'b0);
    wait_rsp(lat);
    chk("post_rst_latency", lat, 1 + SETTLE);
    chk("post_rst_rsp_y", rsp_y, 8'h22);
    chk("post_rst_sweep_done", sweep_done, 0);
    step();
    chk("post_rst_done", rsp_valid, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Initiator side of the combinational alu interface (A, B, S in; Y out).
- Accepts operation commands over a valid/ready handshake and drives registered operands and select onto the ALU.
- Waits a fixed settle time, captures Y, and returns it over a valid/ready response channel.
- Sweep mode steps through every (S, A, B) combination and folds all results into a signature, for self-test of the ALU from a bench or host.

Parameters:
- INPUT_WIDTH, 4, operand width; matches the ALU A/B width.
- OUTPUT_WIDTH, 8, ALU result width.
- SELECT_WIDTH, 2, ALU select width.
- SETTLE_CYCLES, 1, cycles between operand drive and Y capture; legal range 1..15.
- SIG_WIDTH, 16, sweep signature width; must be >= OUTPUT_WIDTH.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer accepts a command this cycle.
- cmd_a  in  INPUT_WIDTH  operand A.
- cmd_b  in  INPUT_WIDTH  operand B.
- cmd_s  in  SELECT_WIDTH  operation select (00 add, 01 multiply, 10 shift, 11 concat).
- cmd_sweep  in  1  1 = run full sweep; cmd_a/b/s ignored.
- alu_a  out  INPUT_WIDTH  registered drive to ALU A.
- alu_b  out  INPUT_WIDTH  registered drive to ALU B.
- alu_s  out  SELECT_WIDTH  registered drive to ALU S.
- alu_y  in  OUTPUT_WIDTH  ALU result Y.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes response.
- rsp_y  out  OUTPUT_WIDTH  captured result.
- rsp_s  out  SELECT_WIDTH  echo of the select that produced rsp_y.
- busy  out  1  high in any state other than IDLE.
- sweep_done  out  1  level; sweep finished.
- sweep_sig  out  SIG_WIDTH  sweep signature.
- sweep_count  out  2*INPUT_WIDTH+SELECT_WIDTH+1  number of results folded.

Behaviour:
- Reset (async assert, sync deassert by design):
  - state = IDLE.
  - alu_a, alu_b, alu_s, rsp_y, rsp_s, sweep_sig and sweep_count = 0.
  - rsp_valid, sweep_done and busy = 0.
  - Reset mid-command or mid-sweep aborts with no response and no partial signature.
- States: IDLE, DRIVE, SETTLE, RESP, SW_DRIVE, SW_SETTLE.
- cmd_ready is 1 only in IDLE; a command is accepted on a cycle where cmd_valid && cmd_ready.
- Single op, with accept at edge 0:
  - alu_a/b/s are loaded at edge 0; go to SETTLE and count SETTLE_CYCLES cycles.
  - At the last settle edge, rsp_y = alu_y, rsp_s = alu_s, rsp_valid = 1, go to RESP.
  - With SETTLE_CYCLES = 1, rsp_valid is high 2 cycles after accept.
  - RESP holds rsp_y, rsp_s and rsp_valid stable until rsp_ready is high at an edge; then rsp_valid = 0 and go to IDLE.
  - If rsp_ready is already high when rsp_valid rises, the response completes in 1 cycle.
  - alu_a/b/s hold their last value in IDLE.
- Sweep:
  - On accept with cmd_sweep = 1: sweep_sig = 0, sweep_count = 0, sweep_done = 0, index = 0.
  - index is 2*INPUT_WIDTH+SELECT_WIDTH bits; alu_s = index[MSBs], alu_a = index[middle], alu_b = index[LSBs].
  - SW_DRIVE loads the drive regs from index; SW_SETTLE waits SETTLE_CYCLES.
  - At the last settle edge, fold alu_y: sweep_sig = rotl1(sweep_sig) XOR zero-extended alu_y, and sweep_count += 1.
  - If index is all-ones, sweep_done = 1 and go to IDLE; otherwise index += 1 and return to SW_DRIVE.
  - Default config: 1024 combinations, (1 + SETTLE_CYCLES) cycles each, so 2048 cycles.
  - Sweep produces no rsp beat.
- sweep_done, sweep_sig and sweep_count hold until the next sweep command is accepted.
- A single op does not clear sweep_done, sweep_sig or sweep_count.
- cmd_valid while busy is ignored; there is no queuing.
- No arithmetic is performed on alu_y; it is passed through opaquely.

Test Plan:
- Reset then idle: all outputs 0 and cmd_ready = 1.
- cmd a=3, b=5, s=00 with rsp_ready = 1 and an add-model ALU:
  - alu_a = 3, alu_b = 5 one cycle after accept.
  - rsp_valid at +2 with rsp_y = 0x08, rsp_s = 00.
  - cmd_ready returns to 1 the next cycle.
- cmd a=7, b=9, s=01 with rsp_ready held low for 5 cycles:
  - rsp_y = 0x3F is held stable with rsp_valid high for all 5 cycles.
  - A cmd_valid pulse during the stall is ignored.
  - The response completes on the first edge where rsp_ready = 1.
- Sweep with the reference ALU model:
  - sweep_done asserts exactly 2048 cycles after accept.
  - sweep_count = 1024.
  - sweep_sig equals the bench-computed rotate-XOR over the model.
  - The last drive is alu_s = 3, alu_a = 15, alu_b = 15.
- rst_n pulsed low mid-sweep (cycle 600):
  - All outputs go to 0 immediately (async).
  - A new single op after release completes normally with sweep_done = 0.
- SETTLE_CYCLES = 3 build: single op rsp_valid at +4 after accept; sweep_done at 4096 cycles.
